// File: rtl/commit_pkg.sv
// Shared widths and entry record for the retirement-to-difftest commit path.
package commit_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned CSR_ID_W = 12;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [INST_W-1:0]   inst;
        logic                is_mmio;
        logic [CSR_ID_W-1:0] rcsr_id;
    } commit_entry_t;

    function automatic commit_entry_t make_entry(
        input logic [PC_W-1:0]     pc,
        input logic [INST_W-1:0]   inst,
        input logic                is_mmio,
        input logic [CSR_ID_W-1:0] rcsr_id
    );
        commit_entry_t e;
        e.pc      = pc;
        e.inst    = inst;
        e.is_mmio = is_mmio;
        e.rcsr_id = rcsr_id;
        return e;
    endfunction

endpackage

// File: rtl/commit_queue_if.sv
// Writeback-side retirement slots, pause control and difftest-side commit outputs.
interface commit_queue_if;
    import commit_pkg::*;

    logic                in0_valid;
    logic [PC_W-1:0]     in0_pc;
    logic [INST_W-1:0]   in0_inst;
    logic                in0_is_mmio;
    logic [CSR_ID_W-1:0] in0_rcsr_id;
    logic                in1_valid;
    logic [PC_W-1:0]     in1_pc;
    logic [INST_W-1:0]   in1_inst;
    logic                in1_is_mmio;
    logic [CSR_ID_W-1:0] in1_rcsr_id;
    logic                in_ready;
    logic                pause;
    logic                out_valid;
    logic [PC_W-1:0]     out_pc;
    logic [INST_W-1:0]   out_inst;
    logic                out_is_mmio;
    logic [CSR_ID_W-1:0] out_rcsr_id;
    logic                empty;
    logic [63:0]         retired_cnt;

    modport master (
        output in0_valid, in0_pc, in0_inst, in0_is_mmio, in0_rcsr_id,
        output in1_valid, in1_pc, in1_inst, in1_is_mmio, in1_rcsr_id,
        output pause,
        input  in_ready, out_valid, out_pc, out_inst, out_is_mmio, out_rcsr_id,
        input  empty, retired_cnt
    );

    modport slave (
        input  in0_valid, in0_pc, in0_inst, in0_is_mmio, in0_rcsr_id,
        input  in1_valid, in1_pc, in1_inst, in1_is_mmio, in1_rcsr_id,
        input  pause,
        output in_ready, out_valid, out_pc, out_inst, out_is_mmio, out_rcsr_id,
        output empty, retired_cnt
    );

endinterface

// File: rtl/commit_queue.sv
// Circular queue accepting up to two in-order retirements per cycle and
// draining one per cycle into the difftest commit hook.
module commit_queue
    import commit_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input logic           clock,
    input logic           reset,
    commit_queue_if.slave bus
);

    localparam int unsigned     PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]  READY_MAX = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    commit_entry_t    mem [DEPTH];

    commit_entry_t in0_entry, in1_entry, wr0_entry, out_entry;
    logic          ready, push, pop, dual;
    logic [1:0]    push_n;
    logic          out_valid_q;
    logic [63:0]   retired_q;

    assign in0_entry = make_entry(bus.in0_pc, bus.in0_inst, bus.in0_is_mmio, bus.in0_rcsr_id);
    assign in1_entry = make_entry(bus.in1_pc, bus.in1_inst, bus.in1_is_mmio, bus.in1_rcsr_id);

    // Ready uses only the registered count; a pop in the same cycle earns no credit.
    always_comb begin
        ready     = (count <= READY_MAX);
        push      = ready & (bus.in0_valid | bus.in1_valid);
        dual      = bus.in0_valid & bus.in1_valid;
        push_n    = 2'd0;
        if (push) push_n = {1'b0, bus.in0_valid} + {1'b0, bus.in1_valid};
        wr0_entry = bus.in0_valid ? in0_entry : in1_entry;
        pop       = (count != '0) & ~bus.pause;
    end

    // Payload storage is not reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr0_entry;
            if (dual) mem[wr_ptr + PTR_W'(1)] <= in1_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_entry   <= '0;
            out_valid_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            wr_ptr      <= wr_ptr + PTR_W'(push_n);
            count       <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop);
            out_valid_q <= pop;
            if (pop) begin
                out_entry <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
                retired_q <= retired_q + 64'd1;
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.empty       = (count == '0);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_entry.pc;
    assign bus.out_inst    = out_entry.inst;
    assign bus.out_is_mmio = out_entry.is_mmio;
    assign bus.out_rcsr_id = out_entry.rcsr_id;
    assign bus.retired_cnt = retired_q;

endmodule
